// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer over a two-half-adder full-adder slice
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             h1s, h1c, s, h2c, c_next, last;

    half_adder u_h1 (.x(opa_q[0]), .y(opb_q[0]), .s(h1s), .c(h1c));
    half_adder u_h2 (.x(h1s), .y(carry_q), .s(s), .c(h2c));

    assign c_next = h1c | h2c;
    assign last   = cnt_q == CNT_W'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                opa_d   = a;
                opb_d   = sub ? ~b : b;
                carry_d = sub;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = (res_q >> 1) | ((WIDTH-1)'(s) << (WIDTH - 2));
                carry_d = c_next;
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    // carry_q is the carry into the MSB on this final bit
                    sum_d   = {s, res_q};
                    cout_d  = c_next;
                    ovf_d   = carry_q ^ c_next;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q == RUN;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vectors plus a transaction-level model checked every cycle
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, sub_i = 0;
    logic [WIDTH-1:0] a_i = 0, b_i = 0;
    logic in_ready, out_valid, cout, ovf, busy;
    logic [WIDTH-1:0] sum;
    int n_checks = 0, n_fail = 0;
    bit check_en = 0;

    serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .sub(sub_i), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer add/sub, signed range test for overflow
    function automatic void calc(input logic [7:0] x, input logic [7:0] y, input logic s,
                                 output logic [7:0] r, output logic c, output logic o);
        int ux = x, uy = y, sx = $signed(x), sy = $signed(y), sr;
        sr = s ? sx - sy : sx + sy;
        r  = s ? 8'(ux - uy) : 8'(ux + uy);
        c  = s ? (ux >= uy) : ((ux + uy) > 255);
        o  = (sr > 127) || (sr < -128);
    endfunction

    int m_phase = 0, m_left = 0;
    logic [7:0] m_sum = 0, p_sum = 0;
    logic m_cout = 0, m_ovf = 0, p_cout = 0, p_ovf = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_sum = 0; m_cout = 0; m_ovf = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                calc(a_i, b_i, sub_i, p_sum, p_cout, p_ovf);
                m_left = WIDTH; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = 2; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else if (out_ready) m_phase = 0;
    end

    always @(negedge clk) if (check_en) begin
        chk("m_in_ready", in_ready, m_phase == 0);
        chk("m_busy", busy, m_phase == 1);
        chk("m_out_valid", out_valid, m_phase == 2);
        chk("m_sum", sum, m_sum);
        chk("m_cout", cout, m_cout);
        chk("m_ovf", ovf, m_ovf);
    end

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                         input logic [7:0] es, input logic ec, input logic eo, input bit toggle);
        int n = 0;
        a_i = ta; b_i = tb_; sub_i = ts; in_valid = 1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_wait", n < 50, 1);
        @(posedge clk); #1;
        in_valid = toggle;
        n = 0;
        while (!out_valid && n < 40) begin
            if (toggle) begin a_i = 8'($urandom); b_i = 8'($urandom); sub_i = 1'($urandom); end
            @(posedge clk); #1; n++;
        end
        in_valid = 0;
        chk("latency", n, 8);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo);
        if (out_ready) begin
            @(posedge clk); #1;
            chk("post_valid", out_valid, 0);
            chk("post_ready", in_ready, 1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0; check_en = 1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);

        do_op(8'h5A, 8'h3C, 0, 8'h96, 0, 1, 0);
        do_op(8'hFF, 8'h01, 0, 8'h00, 1, 0, 0);
        do_op(8'h7F, 8'h01, 0, 8'h80, 0, 1, 0);
        do_op(8'h10, 8'h01, 1, 8'h0F, 1, 0, 0);
        do_op(8'h00, 8'h01, 1, 8'hFF, 0, 0, 0);
        do_op(8'h80, 8'h01, 1, 8'h7F, 1, 1, 0);
        do_op(8'h25, 8'h4A, 0, 8'h6F, 0, 0, 1);

        out_ready = 0;
        do_op(8'hC8, 8'h32, 1, 8'h96, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", sum, 8'h96);
            chk("bp_ready", in_ready, 0);
            in_valid = 1'(i % 2); a_i = 8'(i * 7); b_i = 8'(i + 3);
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_idle_hold", in_ready, 1);

        a_i = 8'h33; b_i = 8'h11; sub_i = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        do_op(8'h01, 8'h01, 0, 8'h02, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1 check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
